// File: rtl/ram_read_arbiter_if.sv
// ram_read_arbiter_if: bundles the requester, response, write and RAM port
// signals of ram_read_arbiter.
//   slave  modport : arbiter view (drives readys, responses and RAM ports)
//   master modport : environment view (drives requests, writes, ram_doutb)
// Parameters WIDTH/DEPTH must match the arbiter instance using it.
interface ram_read_arbiter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             req0_valid;
    logic             req0_ready;
    logic [AW-1:0]    req0_addr;
    logic             req1_valid;
    logic             req1_ready;
    logic [AW-1:0]    req1_addr;
    logic             resp0_valid;
    logic [WIDTH-1:0] resp0_data;
    logic             resp1_valid;
    logic [WIDTH-1:0] resp1_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             ram_write;
    logic [AW-1:0]    ram_addra;
    logic [WIDTH-1:0] ram_dina;
    logic             ram_read;
    logic [AW-1:0]    ram_addrb;
    logic [WIDTH-1:0] ram_doutb;

    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr,
        input  wr_valid, wr_addr, wr_data, ram_doutb,
        output req0_ready, req1_ready, resp0_valid, resp0_data,
        output resp1_valid, resp1_data, wr_ready,
        output ram_write, ram_addra, ram_dina, ram_read, ram_addrb
    );

    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr,
        output wr_valid, wr_addr, wr_data, ram_doutb,
        input  req0_ready, req1_ready, resp0_valid, resp0_data,
        input  resp1_valid, resp1_data, wr_ready,
        input  ram_write, ram_addra, ram_dina, ram_read, ram_addrb
    );
endinterface

// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter: shares one RAM read port between two read requesters
// with round-robin arbitration, and passes a single write requester
// straight through to the RAM write port. Reads that hit the address being
// written in the same cycle are stalled for that cycle. Each accepted read
// is tracked through a READ_LATENCY-deep tag pipeline so its response valid
// is routed to the right requester when the RAM data arrives.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : ram_read_arbiter_if.slave (requests, responses, write, RAM ports)
// Parameters: WIDTH word bits, DEPTH words, READ_LATENCY RAM latency (1..8).
module ram_read_arbiter #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    ram_read_arbiter_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                    last_grant_q;
    logic                    last_grant_d;
    logic [READ_LATENCY-1:0] tag_valid_q;
    logic [READ_LATENCY-1:0] tag_valid_d;
    logic [READ_LATENCY-1:0] tag_id_q;
    logic [READ_LATENCY-1:0] tag_id_d;

    logic                    any_valid;
    logic                    winner;
    logic [AW-1:0]           win_addr;
    logic                    collision;
    logic                    accept;
    logic [WIDTH-1:0]        rd_data;

    // Arbitration and collision detection; readiness never looks at the
    // other requester's ready, only at valids, addresses and the write port.
    always_comb begin
        any_valid    = bus.req0_valid | bus.req1_valid;
        winner       = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = bus.req1_valid;
        end
        win_addr     = winner ? bus.req1_addr : bus.req0_addr;
        collision    = bus.wr_valid && any_valid && (win_addr == bus.wr_addr);
        // rst gating keeps readys and ram_read low throughout reset.
        accept       = any_valid && !collision && !rst;
        last_grant_d = accept ? winner : last_grant_q;
    end

    // Tag pipeline shift: stage 0 takes the current accept.
    if (READ_LATENCY > 1) begin : g_tag_shift
        assign tag_valid_d = {tag_valid_q[READ_LATENCY-2:0], accept};
        assign tag_id_d    = {tag_id_q[READ_LATENCY-2:0], accept & winner};
    end else begin : g_tag_single
        assign tag_valid_d = accept;
        assign tag_id_d    = accept & winner;
    end

    // State registers; reset makes requester 0 win the first arbitration
    // and discards every read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            tag_valid_q  <= '0;
            tag_id_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            tag_valid_q  <= tag_valid_d;
            tag_id_q     <= tag_id_d;
        end
    end

    // Write requester is a straight pass-through.
    assign bus.wr_ready   = 1'b1;
    assign bus.ram_write  = bus.wr_valid;
    assign bus.ram_addra  = bus.wr_addr;
    assign bus.ram_dina   = bus.wr_data;

    // Read port and requester handshakes.
    assign bus.req0_ready = accept & ~winner;
    assign bus.req1_ready = accept & winner;
    assign bus.ram_read   = accept;
    assign bus.ram_addrb  = accept ? win_addr : '0;

    // Responses: data is shared, only the valids are steered by the tag.
    assign rd_data         = bus.ram_doutb;
    assign bus.resp0_data  = rd_data;
    assign bus.resp1_data  = rd_data;
    assign bus.resp0_valid = tag_valid_q[READ_LATENCY-1] & ~tag_id_q[READ_LATENCY-1];
    assign bus.resp1_valid = tag_valid_q[READ_LATENCY-1] & tag_id_q[READ_LATENCY-1];
endmodule
